imem_ring_buffer: RTL and testbench
===================================

# imem_ring_buffer

Instruction memory with a parametrised ring of N instruction buffers. It sits between the AXI instruction loader and the instruction decoder. The loader fills buffers in order using wide multi-instruction beats, and the decoder drains them in the same order one instruction at a time. Each committed block records its own length, so the decoder can read while later blocks are still loading and can never read past the valid data.

## Interface
- NUM_BUFS, 4 — ring depth in blocks; power of 2, ≥2
- NUM_INST_IN, 2 — instructions per write beat; power of 2, ≥1
- INST_DATA_WIDTH, 32 — bits per instruction
- INST_ADDR_WIDTH, 10 — per-buffer instruction address width; buffer depth DEPTH = 2^INST_ADDR_WIDTH
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  pulse; moves the block from IDLE to RUN
- flush  in  1  pulse; discards all blocks and returns to IDLE
- wr_start  out  1  one-cycle pulse; loader may begin streaming a block
- wr_req  out  1  level; a free buffer is open for writing
- wr_data_valid  in  1  write beat strobe
- wr_data  in  NUM_INST_IN*INST_DATA_WIDTH  beat; instruction k is in slice k, lowest address in slice 0
- wr_done  in  1  pulse after the last beat of a block
- wr_overflow  out  1  sticky; a beat arrived beyond DEPTH
- rd_req  in  1  read strobe
- rd_addr  in  INST_ADDR_WIDTH  instruction index within the current block
- rd_data  out  INST_DATA_WIDTH  instruction
- rd_valid  out  1  rd_data is valid
- rd_oob  out  1  one-cycle pulse; the read was at or beyond the block length
- rd_block_done  in  1  pulse; decoder releases the current block
- block_ready  out  1  a committed block is available to read
- block_len  out  INST_ADDR_WIDTH+1  instruction count of the current read block
- occupancy  out  clog2(NUM_BUFS)+1  number of committed blocks

## Operation
- Top state: IDLE or RUN. start in IDLE moves to RUN. flush in any state moves to IDLE.
- Ring bookkeeping:
  - wr_ptr and rd_ptr are clog2(NUM_BUFS) bits wide and wrap modulo NUM_BUFS.
  - occupancy ranges 0..NUM_BUFS.
  - len[NUM_BUFS] holds each block length, INST_ADDR_WIDTH+1 bits.
- Write FSM (WR_WAIT, WR_DATA, WR_COMMIT):
  - WR_WAIT → WR_DATA when in RUN and occupancy < NUM_BUFS.
  - WR_DATA → WR_COMMIT on wr_done.
  - WR_COMMIT → WR_WAIT unconditionally.
- Write-side outputs:
  - wr_req is high exactly in WR_DATA.
  - wr_start is registered, high the cycle after entering WR_DATA.
- Write beats:
  - Beats are accepted only in WR_DATA; beats at any other time are ignored.
  - Beat counter bcnt has INST_ADDR_WIDTH−clog2(NUM_INST_IN)+1 bits.
  - A beat writes bank k at row {wr_ptr, bcnt}, for every k.
  - A beat arriving with bcnt == DEPTH/NUM_INST_IN is dropped and sets wr_overflow. wr_overflow clears only on reset or flush.
- Commit (WR_COMMIT):
  - If bcnt > 0: len[wr_ptr] = bcnt*NUM_INST_IN, wr_ptr++, occupancy++.
  - If bcnt == 0: the block is discarded and no state changes.
  - bcnt is cleared in both cases.
- Read FSM (RD_WAIT, RD_DATA, RD_RELEASE):
  - RD_WAIT → RD_DATA when occupancy > 0.
  - RD_DATA → RD_RELEASE on rd_block_done.
  - RD_RELEASE → RD_WAIT; on this transition rd_ptr++ and occupancy−−.
- Read-side outputs:
  - block_ready is high exactly in RD_DATA.
  - block_len = len[rd_ptr].
- Reads:
  - rd_req in RD_DATA with rd_addr < block_len: rd_valid = 1 next cycle.
  - rd_req in RD_DATA with rd_addr ≥ block_len: rd_oob = 1 next cycle and rd_valid = 0.
  - rd_req outside RD_DATA produces no response.
- Read datapath:
  - Bank select = rd_addr[clog2(NUM_INST_IN)−1:0], registered one cycle.
  - Row = {rd_ptr, rd_addr[INST_ADDR_WIDTH−1:clog2(NUM_INST_IN)]}.
  - With NUM_INST_IN = 1 there is no select field and a single bank.
- Simultaneous commit and release in one cycle: occupancy unchanged, both pointers advance.
- Read and write of the same buffer cannot occur: a buffer is never both the write target and a committed block.
- flush and reset:
  - Clear pointers, occupancy, bcnt, len and wr_overflow.
  - Both FSMs go to WAIT and the top state goes to IDLE.
  - Memory contents are not cleared.
  - A flush mid-stream drops the block being written.

## Timing
- Reset values: wr_start=0, wr_req=0, wr_overflow=0, rd_data=0, rd_valid=0, rd_oob=0, block_ready=0, block_len=0, occupancy=0.
- Read latency: 1 cycle from rd_req to rd_valid/rd_data. Back-to-back reads are supported at one per cycle.
- Commit to visibility:
  - Occupancy updates in the cycle after WR_COMMIT.
  - block_ready rises 1 cycle after that, once the read FSM enters RD_DATA.
  - With an empty ring, the minimum time from wr_done to block_ready is 3 cycles.
- Release to next block: block_ready drops the cycle after rd_block_done. If another block is committed, block_ready reasserts 2 cycles later.
- A write to a row and a read of the same row in the same cycle cannot happen, by construction.

## Structure
- Shared package imem_pkg holds:
  - top, write-FSM and read-FSM state encodings (2 bits each);
  - helper localparams BUF_W, SEL_W, ROW_W derived via $clog2.
- Sub-module: the existing simple dual-port ram. Instantiate NUM_INST_IN banks, each DATA_WIDTH = INST_DATA_WIDTH and ADDR_WIDTH = clog2(NUM_BUFS)+INST_ADDR_WIDTH−SEL_W.
- The bank-select delay uses register_sync.

## Test plan
- Reset, start, then one block of 3 beats with NUM_INST_IN=2, then wr_done → block_len=6, occupancy=1. Reads at addr 0..5 return the 6 instructions in beat order, each 1 cycle later. A read at addr 6 gives rd_oob=1 and rd_valid=0.
- NUM_BUFS=4: commit 4 blocks with no reads → wr_req stays low and occupancy=4. Then rd_block_done → a fifth block is accepted into buffer 0 (wrap) and returns its own data.
- Commit and release in the same cycle with occupancy=2 → occupancy stays 2 and both pointers advance by 1.
- wr_done with zero beats → occupancy unchanged, block_ready stays 0, and the next block uses the same buffer.
- Write DEPTH/NUM_INST_IN+1 beats → wr_overflow=1, block_len=DEPTH, and the last beat is not written.
- flush mid-write with occupancy=2 → occupancy=0, block_ready=0, wr_req=0. A fresh start then works from buffer 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared encodings and default-geometry widths for the instruction-memory ring.
// Pure declarations; no logic.
package imem_pkg;

    typedef enum logic [1:0] {
        TOP_IDLE = 2'd0,
        TOP_RUN  = 2'd1
    } top_state_t;

    typedef enum logic [1:0] {
        WR_WAIT   = 2'd0,
        WR_DATA   = 2'd1,
        WR_COMMIT = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_WAIT    = 2'd0,
        RD_DATA    = 2'd1,
        RD_RELEASE = 2'd2
    } rd_state_t;

    localparam int DEF_NUM_BUFS        = 4;
    localparam int DEF_NUM_INST_IN     = 2;
    localparam int DEF_INST_ADDR_WIDTH = 10;

    // Widths for the default geometry; a value of 0 for SEL_W means a single bank.
    localparam int BUF_W = $clog2(DEF_NUM_BUFS);
    localparam int SEL_W = $clog2(DEF_NUM_INST_IN);
    localparam int ROW_W = DEF_INST_ADDR_WIDTH - SEL_W;

endpackage

// File: rtl/register_sync.sv
// Plain D register with synchronous active-high reset.
// Latency: 1 cycle. No backpressure.
module register_sync #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= RESET_VAL;
        else       q <= d;
    end

endmodule

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
// Latency: 1 cycle read. No backpressure.
module sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/imem_ring_buffer.sv
// Ring of NUM_BUFS instruction blocks: wide in-order fill from the loader, single-instruction reads by the decoder.
// Latency: 1 cycle rd_req to rd_valid/rd_oob; commit becomes readable 3 cycles after wr_done on an empty ring.
// Backpressure: wr_req drops while the ring is full; decoder holds a block until rd_block_done.
module imem_ring_buffer
    import imem_pkg::*;
#(
    parameter int NUM_BUFS        = DEF_NUM_BUFS,
    parameter int NUM_INST_IN     = DEF_NUM_INST_IN,
    parameter int INST_DATA_WIDTH = 32,
    parameter int INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   flush,
    output logic                                   wr_start,
    output logic                                   wr_req,
    input  logic                                   wr_data_valid,
    input  logic [NUM_INST_IN*INST_DATA_WIDTH-1:0] wr_data,
    input  logic                                   wr_done,
    output logic                                   wr_overflow,
    input  logic                                   rd_req,
    input  logic [INST_ADDR_WIDTH-1:0]             rd_addr,
    output logic [INST_DATA_WIDTH-1:0]             rd_data,
    output logic                                   rd_valid,
    output logic                                   rd_oob,
    input  logic                                   rd_block_done,
    output logic                                   block_ready,
    output logic [INST_ADDR_WIDTH:0]               block_len,
    output logic [$clog2(NUM_BUFS):0]              occupancy
);

    localparam int PTR_W     = $clog2(NUM_BUFS);
    localparam int BSEL_W    = $clog2(NUM_INST_IN);
    localparam int RAM_ROW_W = INST_ADDR_WIDTH - BSEL_W;
    localparam int RAM_AW    = PTR_W + RAM_ROW_W;
    localparam int LEN_W     = INST_ADDR_WIDTH + 1;
    localparam int BCNT_W    = RAM_ROW_W + 1;
    localparam int OCC_W     = PTR_W + 1;

    localparam logic [BCNT_W-1:0] BEAT_MAX = {1'b1, {RAM_ROW_W{1'b0}}};
    localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(NUM_BUFS);

    top_state_t        top_state;
    wr_state_t         wr_state;
    rd_state_t         rd_state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [BCNT_W-1:0] bcnt;
    logic [LEN_W-1:0]  len [NUM_BUFS];

    logic beat_in;
    logic beat_acc;
    logic beat_drop;
    logic commit;
    logic release_blk;
    logic wr_open;
    logic rd_hit;
    logic rd_in_range;

    assign beat_in     = (wr_state == WR_DATA) && wr_data_valid;
    assign beat_acc    = beat_in && (bcnt != BEAT_MAX);
    assign beat_drop   = beat_in && (bcnt == BEAT_MAX);
    // An empty block is discarded so the decoder never sees a zero-length buffer.
    assign commit      = (wr_state == WR_COMMIT) && (bcnt != '0);
    assign release_blk = (rd_state == RD_RELEASE);
    assign wr_open     = (wr_state == WR_WAIT) && (top_state == TOP_RUN) && (occ != OCC_FULL);
    assign rd_hit      = rd_req && (rd_state == RD_DATA);
    assign rd_in_range = LEN_W'(rd_addr) < block_len;

    assign wr_req      = (wr_state == WR_DATA);
    assign block_ready = (rd_state == RD_DATA);
    assign block_len   = len[rd_ptr];
    assign occupancy   = occ;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            top_state   <= TOP_IDLE;
            wr_state    <= WR_WAIT;
            rd_state    <= RD_WAIT;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            bcnt        <= '0;
            wr_overflow <= 1'b0;
            wr_start    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_oob      <= 1'b0;
            for (int i = 0; i < NUM_BUFS; i++) len[i] <= '0;
        end else begin
            if (top_state == TOP_IDLE && start) top_state <= TOP_RUN;

            wr_start <= wr_open;
            case (wr_state)
                WR_WAIT:   if (wr_open) wr_state <= WR_DATA;
                WR_DATA:   if (wr_done) wr_state <= WR_COMMIT;
                WR_COMMIT: wr_state <= WR_WAIT;
                default:   wr_state <= WR_WAIT;
            endcase

            if (beat_acc)  bcnt <= bcnt + BCNT_W'(1);
            if (beat_drop) wr_overflow <= 1'b1;

            if (wr_state == WR_COMMIT) begin
                bcnt <= '0;
                if (commit) begin
                    len[wr_ptr] <= LEN_W'(bcnt) << BSEL_W;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
            end

            case ({commit, release_blk})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase

            case (rd_state)
                RD_WAIT:    if (occ != '0) rd_state <= RD_DATA;
                RD_DATA:    if (rd_block_done) rd_state <= RD_RELEASE;
                RD_RELEASE: begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    rd_state <= RD_WAIT;
                end
                default:    rd_state <= RD_WAIT;
            endcase

            rd_valid <= rd_hit && rd_in_range;
            rd_oob   <= rd_hit && !rd_in_range;
        end
    end

    logic [RAM_AW-1:0]          wr_row;
    logic [RAM_AW-1:0]          rd_row;
    logic [INST_DATA_WIDTH-1:0] bank_rd [NUM_INST_IN];
    logic [INST_DATA_WIDTH-1:0] sel_data;

    assign wr_row = {wr_ptr, bcnt[RAM_ROW_W-1:0]};
    assign rd_row = {rd_ptr, rd_addr[INST_ADDR_WIDTH-1:BSEL_W]};

    for (genvar k = 0; k < NUM_INST_IN; k++) begin : g_bank
        sdp_ram #(
            .DATA_WIDTH (INST_DATA_WIDTH),
            .ADDR_WIDTH (RAM_AW)
        ) u_bank (
            .clk     (clk),
            .wr_en   (beat_acc),
            .wr_addr (wr_row),
            .wr_data (wr_data[k*INST_DATA_WIDTH +: INST_DATA_WIDTH]),
            .rd_en   (rd_hit),
            .rd_addr (rd_row),
            .rd_data (bank_rd[k])
        );
    end

    if (BSEL_W > 0) begin : g_sel
        logic [BSEL_W-1:0] rd_sel_q;

        register_sync #(
            .WIDTH (BSEL_W)
        ) u_sel_dly (
            .clk   (clk),
            .reset (reset),
            .d     (rd_addr[BSEL_W-1:0]),
            .q     (rd_sel_q)
        );

        assign sel_data = bank_rd[rd_sel_q];
    end else begin : g_nosel
        assign sel_data = bank_rd[0];
    end

    // Gate with rd_valid so rd_data reads as zero whenever no instruction is presented.
    assign rd_data = rd_valid ? sel_data : '0;

endmodule

// File: tb/tb_imem_ring_buffer.sv
// Self-checking bench for imem_ring_buffer: scoreboard of read responses plus per-scenario state checks.
module tb_imem_ring_buffer;
    import imem_pkg::*;

    localparam int NB        = 4;
    localparam int NI        = 2;
    localparam int DW        = 32;
    localparam int AW        = 10;
    localparam int DEPTH     = 1 << AW;
    localparam int MAX_BEATS = 1 << ROW_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              flush;
    logic              wr_start;
    logic              wr_req;
    logic              wr_data_valid;
    logic [NI*DW-1:0]  wr_data;
    logic              wr_done;
    logic              wr_overflow;
    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              rd_oob;
    logic              rd_block_done;
    logic              block_ready;
    logic [AW:0]       block_len;
    logic [$clog2(NB):0] occupancy;

    imem_ring_buffer #(
        .NUM_BUFS        (NB),
        .NUM_INST_IN     (NI),
        .INST_DATA_WIDTH (DW),
        .INST_ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .flush         (flush),
        .wr_start      (wr_start),
        .wr_req        (wr_req),
        .wr_data_valid (wr_data_valid),
        .wr_data       (wr_data),
        .wr_done       (wr_done),
        .wr_overflow   (wr_overflow),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_oob        (rd_oob),
        .rd_block_done (rd_block_done),
        .block_ready   (block_ready),
        .block_len     (block_len),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          oob;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [DW-1:0] pat(input int tag, input int idx);
        logic [15:0] t;
        logic [15:0] i;
        t = 16'(tag);
        i = 16'(idx);
        return {t ^ 16'h5A00, i};
    endfunction

    // Scoreboard: every DUT response is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (rd_valid || rd_oob) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: valid=%0b oob=%0b data=%h, required no response",
                         rd_valid, rd_oob, rd_data);
            end else begin
                mon_e = sb.pop_front();
                if (rd_oob !== mon_e.oob || rd_valid !== !mon_e.oob ||
                    (!mon_e.oob && rd_data !== mon_e.data)) begin
                    n_fail++;
                    $display("FAIL rd_resp: valid=%0b oob=%0b data=%h, required oob=%0b data=%h",
                             rd_valid, rd_oob, rd_data, mon_e.oob, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; flush = 1'b0; wr_data_valid = 1'b0; wr_data = '0; wr_done = 1'b0;
        rd_req = 1'b0; rd_addr = '0; rd_block_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic open_block();
        int  n;
        logic was_low;
        n = 0;
        was_low = !wr_req;
        while (!wr_req && n < 40) begin tick(); n++; end
        n_cmp++;
        if (wr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_req_wait: wr_req=%0b after %0d cycles, required 1", wr_req, n);
        end else if (was_low && wr_start !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_start_pulse: wr_start=%0b on first wr_req cycle, required 1", wr_start);
        end
    endtask

    task automatic send_beats(input int tag, input int first, input int nbeats);
        for (int b = first; b < first + nbeats; b++) begin
            wr_data_valid = 1'b1;
            wr_data = {pat(tag, 2*b+1), pat(tag, 2*b)};
            tick();
        end
        wr_data_valid = 1'b0;
    endtask

    task automatic finish_block();
        wr_done = 1'b1; tick(); wr_done = 1'b0;
    endtask

    task automatic write_block(input int tag, input int nbeats);
        open_block();
        send_beats(tag, 0, nbeats);
        finish_block();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!block_ready && n < 40) begin tick(); n++; end
        n_cmp++;
        if (block_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL block_ready_wait: block_ready=%0b after %0d cycles, required 1", block_ready, n);
        end
    endtask

    task automatic read_range(input int tag, input int len, input int lo, input int hi);
        exp_t e;
        for (int a = lo; a <= hi; a++) begin
            rd_req = 1'b1;
            rd_addr = AW'(a);
            e.oob = (a >= len);
            e.data = pat(tag, a);
            sb.push_back(e);
            tick();
        end
        rd_req = 1'b0;
        tick(); tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rd_drain: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic release_block();
        rd_block_done = 1'b1; tick(); rd_block_done = 1'b0;
        n_cmp++;
        if (block_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL release_drop: block_ready=%0b, required 0", block_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; flush = 1'b0; wr_data_valid = 1'b0; wr_data = '1; wr_done = 1'b0;
        rd_req = 1'b0; rd_addr = '0; rd_block_done = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({wr_start, wr_req, wr_overflow, rd_valid, rd_oob, block_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: st=%0b req=%0b ovf=%0b vld=%0b oob=%0b rdy=%0b, required all 0",
                     wr_start, wr_req, wr_overflow, rd_valid, rd_oob, block_ready);
        end
        n_cmp++;
        if (rd_data !== '0 || block_len !== '0 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL reset_values: rd_data=%h block_len=%0d occupancy=%0d, required 0/0/0",
                     rd_data, block_len, occupancy);
        end
        reset = 1'b0;
        tick(); tick();
        n_cmp++;
        if (wr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: wr_req=%0b before start, required 0", wr_req);
        end
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        do_start();
        write_block(1, 3);
        wait_ready(n);
        n_cmp++;
        if (n != 2) begin
            n_fail++;
            $display("FAIL commit_latency: block_ready after %0d cycles past wr_done cycle+1, required 2", n);
        end
        n_cmp++;
        if (block_len !== 11'd6 || occupancy !== 3'd1) begin
            n_fail++;
            $display("FAIL basic_len_occ: block_len=%0d occupancy=%0d, required 6/1", block_len, occupancy);
        end
        read_range(1, 6, 0, 6);
        release_block();
        rd_req = 1'b1; rd_addr = '0; tick(); rd_req = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_outside_data: valid=%0b oob=%0b, required 0/0", rd_valid, rd_oob);
        end
        tick(); tick();
    endtask

    task automatic test_full_wrap();
        int n;
        int hi_seen;
        do_reset();
        do_start();
        for (int t = 2; t <= 5; t++) write_block(t, 2);
        tick(); tick(); tick();
        n_cmp++;
        if (wr_req !== 1'b0 || occupancy !== 3'd4) begin
            n_fail++;
            $display("FAIL full_state: wr_req=%0b occupancy=%0d, required 0/4", wr_req, occupancy);
        end
        hi_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (wr_req) hi_seen++;
            tick();
        end
        n_cmp++;
        if (hi_seen != 0) begin
            n_fail++;
            $display("FAIL full_hold: wr_req high %0d cycles while full, required 0", hi_seen);
        end
        wait_ready(n);
        read_range(2, 4, 0, 4);
        release_block();
        write_block(6, 3);
        for (int t = 3; t <= 5; t++) begin
            wait_ready(n);
            if (t == 4) begin
                n_cmp++;
                if (n != 2) begin
                    n_fail++;
                    $display("FAIL reassert_latency: block_ready after %0d cycles, required 2", n);
                end
            end
            read_range(t, 4, 0, 4);
            release_block();
        end
        wait_ready(n);
        n_cmp++;
        if (block_len !== 11'd6) begin
            n_fail++;
            $display("FAIL wrap_len: block_len=%0d, required 6", block_len);
        end
        read_range(6, 6, 0, 6);
        release_block();
    endtask

    task automatic test_commit_release();
        int n;
        do_reset();
        do_start();
        write_block(7, 2);
        write_block(8, 2);
        wait_ready(n);
        tick(); tick();
        n_cmp++;
        if (occupancy !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_same_cycle_occ: occupancy=%0d, required 2", occupancy);
        end
        open_block();
        send_beats(9, 0, 1);
        wr_done = 1'b1; rd_block_done = 1'b1;
        tick();
        wr_done = 1'b0; rd_block_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (occupancy !== 3'd2) begin
                n_fail++;
                $display("FAIL same_cycle_occ: cycle %0d occupancy=%0d, required 2", c, occupancy);
            end
        end
        wait_ready(n);
        n_cmp++;
        if (block_len !== 11'd4) begin
            n_fail++;
            $display("FAIL same_cycle_rdptr: block_len=%0d, required 4", block_len);
        end
        read_range(8, 4, 0, 4);
        release_block();
        wait_ready(n);
        n_cmp++;
        if (block_len !== 11'd2) begin
            n_fail++;
            $display("FAIL same_cycle_wrptr: block_len=%0d, required 2", block_len);
        end
        read_range(9, 2, 0, 2);
        release_block();
    endtask

    task automatic test_zero_beat();
        int n;
        do_reset();
        do_start();
        open_block();
        finish_block();
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (occupancy !== '0 || block_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_beat: cycle %0d occupancy=%0d block_ready=%0b, required 0/0",
                         c, occupancy, block_ready);
            end
            tick();
        end
        write_block(10, 3);
        wait_ready(n);
        n_cmp++;
        if (block_len !== 11'd6 || occupancy !== 3'd1) begin
            n_fail++;
            $display("FAIL zero_beat_next: block_len=%0d occupancy=%0d, required 6/1", block_len, occupancy);
        end
        read_range(10, 6, 0, 6);
        release_block();
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        do_start();
        open_block();
        send_beats(11, 0, MAX_BEATS);
        n_cmp++;
        if (wr_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_at_full: wr_overflow=%0b after %0d beats, required 0", wr_overflow, MAX_BEATS);
        end
        send_beats(11, MAX_BEATS, 1);
        n_cmp++;
        if (wr_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: wr_overflow=%0b, required 1", wr_overflow);
        end
        finish_block();
        wait_ready(n);
        n_cmp++;
        if (block_len !== 11'(DEPTH)) begin
            n_fail++;
            $display("FAIL ovf_len: block_len=%0d, required %0d", block_len, DEPTH);
        end
        read_range(11, DEPTH, 0, 1);
        read_range(11, DEPTH, DEPTH-2, DEPTH-1);
        n_cmp++;
        if (wr_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: wr_overflow=%0b, required 1", wr_overflow);
        end
        flush = 1'b1; tick(); flush = 1'b0;
        n_cmp++;
        if (wr_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_flush_clear: wr_overflow=%0b, required 0", wr_overflow);
        end
    endtask

    task automatic test_flush();
        int n;
        do_reset();
        do_start();
        write_block(20, 2);
        write_block(21, 2);
        open_block();
        send_beats(22, 0, 2);
        flush = 1'b1; tick(); flush = 1'b0;
        n_cmp++;
        if (occupancy !== '0 || block_ready !== 1'b0 || wr_req !== 1'b0 || block_len !== '0) begin
            n_fail++;
            $display("FAIL flush_state: occ=%0d rdy=%0b req=%0b len=%0d, required 0/0/0/0",
                     occupancy, block_ready, wr_req, block_len);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (wr_req !== 1'b0 || block_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: wr_req=%0b block_ready=%0b, required 0/0", wr_req, block_ready);
        end
        do_start();
        write_block(23, 1);
        wait_ready(n);
        n_cmp++;
        if (block_len !== 11'd2 || occupancy !== 3'd1) begin
            n_fail++;
            $display("FAIL flush_restart: block_len=%0d occupancy=%0d, required 2/1", block_len, occupancy);
        end
        read_range(23, 2, 0, 2);
        release_block();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_commit_release();
        test_zero_beat();
        test_overflow();
        test_flush();
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
